shift_register_debounced: RTL and testbench

- Parametrised, clocked universal shift register with WIDTH bits.
- Four modes: hold, shift-left, shift-right, parallel load. Exactly one operation per debounced push-button press.
- Each register bit is shown as a 0/1 on its own seven-segment digit; an LED indicates an accepted press.
- Sits between the board switches/push button and the HEX display bank; replaces the unclocked switch-sensitive shifter.

---
 rtl/shift_register_debounced.sv | 171 +++++++++++++++++
 tb/tb_shift_register_debounced.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_debounced.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | shift_register_debounced                                                  |
// | Universal shift register (hold/left/right/load) stepped once per debounced|
// | push-button press, with per-bit seven-segment display and press LED.     |
// | Optional macro: ROTATE_EN adds a rotate input for circular shifts.        |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module shift_register_debounced #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_button_n,
    input  logic [1:0]           mode,
    input  logic                 serial_left,
    input  logic                 serial_right,
`ifdef ROTATE_EN
    input  logic                 rotate,
`endif
    input  logic [WIDTH-1:0]     load_data,
    output logic [WIDTH-1:0]     data_q,
    output logic [7*WIDTH-1:0]   hex,
    output logic                 led,
    output logic [CNT_W-1:0]     step_count
);

    localparam int                c_db_w      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_db_w-1:0] c_db_reload = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_db_w-1:0] c_db_one    = c_db_w'(1);
    localparam logic [6:0]        c_seg_zero  = 7'b0000001;
    localparam logic [6:0]        c_seg_one   = 7'b1001111;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    logic               r_sync1;
    logic               r_sync2;
    logic [1:0]         r_sync_vld;
    logic               r_armed;
    state_t             r_state;
    logic [c_db_w-1:0]  r_cnt;
    logic               r_step;
    logic               r_led;
    logic [WIDTH-1:0]   r_data;
    logic [CNT_W-1:0]   r_step_count;
    logic [7*WIDTH-1:0] r_hex;
    logic [7*WIDTH-1:0] w_hex_next;
    logic               w_btn_low;
    logic               w_left_in;
    logic               w_right_in;

    // The button only arms once a genuine released level has passed the
    // synchroniser, so a button held through reset cannot produce a step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_sync_vld <= 2'b00;
            r_armed    <= 1'b0;
        end else begin
            r_sync1    <= push_button_n;
            r_sync2    <= r_sync1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            if (r_sync_vld[1] && r_sync2) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_btn_low = ~r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_step  <= 1'b0;
            r_led   <= 1'b0;
        end else begin
            r_step <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_btn_low && r_armed) begin
                        r_cnt   <= c_db_reload;
                        r_state <= S_PRESS_WAIT;
                    end
                end
                S_PRESS_WAIT: begin
                    if (!w_btn_low) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == c_db_one) begin
                        r_state <= S_PRESSED;
                        r_step  <= 1'b1;
                        r_led   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_db_one;
                    end
                end
                S_PRESSED: begin
                    if (!w_btn_low) begin
                        r_cnt   <= c_db_reload;
                        r_state <= S_RELEASE_WAIT;
                    end
                end
                S_RELEASE_WAIT: begin
                    if (w_btn_low) begin
                        r_state <= S_PRESSED;
                    end else if (r_cnt == c_db_one) begin
                        r_state <= S_IDLE;
                        r_led   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_db_one;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ROTATE_EN
    assign w_left_in  = rotate ? r_data[WIDTH-1] : serial_left;
    assign w_right_in = rotate ? r_data[0]       : serial_right;
`else
    assign w_left_in  = serial_left;
    assign w_right_in = serial_right;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data       <= '0;
            r_step_count <= '0;
        end else if (r_step) begin
            case (mode)
                2'b01:   r_data <= {r_data[WIDTH-2:0], w_left_in};
                2'b10:   r_data <= {w_right_in, r_data[WIDTH-1:1]};
                2'b11:   r_data <= load_data;
                default: r_data <= r_data;
            endcase
            r_step_count <= r_step_count + CNT_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_hex
            assign w_hex_next[7*gi +: 7] = r_data[gi] ? c_seg_one : c_seg_zero;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex <= {WIDTH{c_seg_zero}};
        end else begin
            r_hex <= w_hex_next;
        end
    end

    assign data_q     = r_data;
    assign hex        = r_hex;
    assign led        = r_led;
    assign step_count = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_shift_register_debounced.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_shift_register_debounced                                               |
// | Self-checking bench: vector table, corner sequences, randomized presses.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_shift_register_debounced;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int CW = 3;
    localparam int MASK = (1 << W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pb_n = 1'b1;
    logic [1:0]       mode = 2'b00;
    logic             sl = 1'b0;
    logic             sr = 1'b0;
    logic [W-1:0]     ld = '0;
    logic [W-1:0]     data_q;
    logic [7*W-1:0]   hex;
    logic             led;
    logic [CW-1:0]    step_count;
`ifdef ROTATE_EN
    logic             rotate = 1'b0;
`endif

    int n_vec  = 0;
    int n_fail = 0;
    int m_data = 0;
    int m_cnt  = 0;

    shift_register_debounced #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .push_button_n(pb_n), .mode(mode),
        .serial_left(sl), .serial_right(sr),
`ifdef ROTATE_EN
        .rotate(rotate),
`endif
        .load_data(ld), .data_q(data_q), .hex(hex), .led(led),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   mode;
        logic         sl;
        logic         sr;
        logic [W-1:0] ld;
        logic [W-1:0] exp;
    } vec_t;

    function automatic logic [7*W-1:0] hex_of(input int d);
        logic [7*W-1:0] h;
        for (int i = 0; i < W; i++) begin
            h[7*i +: 7] = ((d >> i) & 1) != 0 ? 7'b1001111 : 7'b0000001;
        end
        return h;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic [1:0] md, input logic s_l, input logic s_r, input int l);
        case (md)
            2'b01:   m_data = ((m_data << 1) | int'(s_l)) & MASK;
            2'b10:   m_data = (m_data >> 1) | (int'(s_r) << (W - 1));
            2'b11:   m_data = l & MASK;
            default: m_data = m_data;
        endcase
        m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    task automatic press(input int low_cycles);
        pb_n = 1'b0;
        tick(low_cycles);
        if (low_cycles >= D + 2) check("led_held", led, 1'b1);
        pb_n = 1'b1;
        tick(D + 6);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_data"}, data_q, m_data[W-1:0]);
        check({tag, "_hex"}, hex, hex_of(m_data));
        check({tag, "_count"}, step_count, m_cnt[CW-1:0]);
        check({tag, "_led"}, led, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   gl;
        tbl[0] = '{2'b01, 1'b1, 1'b0, 4'b0000, 4'b0101};
        tbl[1] = '{2'b10, 1'b0, 1'b1, 4'b0000, 4'b1010};
        tbl[2] = '{2'b00, 1'b1, 1'b1, 4'b1111, 4'b1010};
        tbl[3] = '{2'b11, 1'b0, 1'b0, 4'b0011, 4'b0011};
        tbl[4] = '{2'b01, 1'b0, 1'b1, 4'b1100, 4'b0110};
        tbl[5] = '{2'b10, 1'b0, 1'b0, 4'b1001, 4'b0011};
        tbl[6] = '{2'b01, 1'b1, 1'b0, 4'b0000, 4'b0111};
        tbl[7] = '{2'b10, 1'b0, 1'b1, 4'b0000, 4'b1011};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick(2);
        check("rst_data", data_q, '0);
        check("rst_count", step_count, '0);
        check("rst_led", led, 1'b0);
        check("rst_hex", hex, {W{7'b0000001}});
        rst_n = 1'b1;
        tick(5);

        // Parallel load with exact latency: step at edge 2+D, data at 2+D+1.
        mode = 2'b11; ld = 4'b1010;
        pb_n = 1'b0;
        tick(D + 1);
        check("lat_led_early", led, 1'b0);
        tick(1);
        check("lat_led_on", led, 1'b1);
        check("lat_data_early", data_q, 4'b0000);
        tick(1);
        check("lat_data", data_q, 4'b1010);
        check("lat_hex_lag", hex, {W{7'b0000001}});
        check("lat_count", step_count, 3'd1);
        tick(1);
        check("lat_hex", hex, {7'b1001111, 7'b0000001, 7'b1001111, 7'b0000001});
        tick(2);
        pb_n = 1'b1;
        tick(D + 6);
        check("lat_led_off", led, 1'b0);
        m_data = 4'b1010; m_cnt = 1;

        for (int i = 0; i < 8; i++) begin
            mode = tbl[i].mode; sl = tbl[i].sl; sr = tbl[i].sr; ld = tbl[i].ld;
            press(10);
            m_cnt = (m_cnt + 1) % (1 << CW);
            m_data = int'(tbl[i].exp);
            check("tbl_data", data_q, tbl[i].exp);
            check("tbl_hex", hex, hex_of(int'(tbl[i].exp)));
            check("tbl_count", step_count, m_cnt[CW-1:0]);
        end

        // Input changes without a press must not disturb the register.
        for (int i = 0; i < 6; i++) begin
            mode = 2'($urandom_range(0, 3)); ld = W'($urandom_range(0, MASK));
            sl = 1'($urandom_range(0, 1)); sr = 1'($urandom_range(0, 1));
            tick(1);
        end
        check_model("nostep");

        // Short bounces: D-1 low samples never reach PRESSED.
        for (int g = 0; g < 5; g++) begin
            pb_n = 1'b0;
            for (int c = 0; c < 3; c++) begin
                tick(1);
                check("bounce_led", led, 1'b0);
            end
            pb_n = 1'b1;
            tick(6);
        end
        check_model("bounce");

        mode = 2'b00;
        press(100);
        model_step(2'b00, 1'b0, 1'b0, 0);
        check_model("long_hold");

        for (int r = 0; r < 40; r++) begin
            mode = 2'($urandom_range(0, 3)); ld = W'($urandom_range(0, MASK));
            sl = 1'($urandom_range(0, 1)); sr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                gl = $urandom_range(1, D - 1);
                pb_n = 1'b0;
                tick(gl);
                pb_n = 1'b1;
                tick(5);
            end
            press($urandom_range(D + 2, 14));
            model_step(mode, sl, sr, int'(ld));
            check_model("rand");
        end

        // Async reset while pressed; button still held afterwards must not step.
        mode = 2'b11; ld = 4'b1111;
        pb_n = 1'b0;
        tick(D + 4);
        check("mid_led", led, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_data", data_q, '0);
        check("async_count", step_count, '0);
        check("async_led", led, 1'b0);
        check("async_hex", hex, {W{7'b0000001}});
        tick(2);
        rst_n = 1'b1;
        m_data = 0; m_cnt = 0;
        tick(20);
        check_model("held_after_rst");
        pb_n = 1'b1;
        tick(D + 6);

        mode = 2'b00;
        for (int p = 0; p < 8; p++) begin
            press(D + 3);
            model_step(2'b00, 1'b0, 1'b0, 0);
            if (p == 6) check("wrap_pre", step_count, 3'd7);
        end
        check("wrap_count", step_count, 3'd0);
        check("wrap_data", data_q, 4'b0000);

`ifdef ROTATE_EN
        mode = 2'b11; ld = 4'b1000;
        press(10);
        rotate = 1'b1; sl = 1'b0; sr = 1'b0;
        mode = 2'b01;
        press(10);
        check("rot_left", data_q, 4'b0001);
        mode = 2'b10; sr = 1'b0;
        press(10);
        check("rot_right", data_q, 4'b1000);
        rotate = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
